systolic_result_drain: RTL and testbench
========================================

Name: systolic_result_drain

Overview:
Reader side of the PE array accumulator outputs. On a capture request it snapshots every PE accumulator from the flattened array bus in one cycle, so the array may be reset or restarted immediately afterwards. It then streams the results out in row-major order over a valid/ready interface, converting each value to the output width with optional signed saturation. It sits between the systolic array and the result memory/host writeback path.

Parameters:
ROWS, 4, PE rows in the array (>=1)
COLS, 4, PE columns in the array (>=1)
ACCUM_WIDTH, 40, width of each PE accumulator (signed two's complement)
OUT_WIDTH, 32, width of each streamed result (>=2)
SATURATE, 1, 1 = clamp to OUT_WIDTH signed range; 0 = keep low OUT_WIDTH bits

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
capture  input  1  single-cycle request to snapshot the array and start draining
accum_in  input  ROWS*COLS*ACCUM_WIDTH  flattened accumulators; element (r,c) at [(r*COLS+c)*ACCUM_WIDTH +: ACCUM_WIDTH]
busy  output  1  high from the cycle after an accepted capture until done
out_valid  output  1  out_data/out_row/out_col/out_last are valid
out_ready  input  1  downstream accepts the current word
out_data  output  OUT_WIDTH  converted result
out_row  output  clog2(ROWS) (min 1)  row index of the current word
out_col  output  clog2(COLS) (min 1)  column index of the current word
out_last  output  1  current word is element (ROWS-1,COLS-1)
done  output  1  one-cycle pulse after the last word transfers

Behaviour:
- Reset (async, any time, including mid-stream): state=IDLE, snapshot cleared to 0, index 0; busy, out_valid, out_last, done, out_data, out_row, out_col all 0. Any stream in progress is abandoned and no done pulse is produced.
- States: IDLE, STREAM, DONE.
- IDLE: capture=1 at edge -> latch all of accum_in into the snapshot registers, index=0, go STREAM. busy and out_valid are 1 on the next cycle (1-cycle capture-to-valid latency).
- capture while STREAM or DONE is ignored; the snapshot is not overwritten.
- STREAM: out_valid=1 continuously. A transfer occurs on a rising edge with out_valid&&out_ready. On a transfer: if index == ROWS*COLS-1 go DONE, else index+1. Without a transfer, out_data/out_row/out_col/out_last hold stable.
- out_row = index / COLS, out_col = index % COLS (maintained as separate counters; col wraps COLS-1 -> 0 with row+1). out_last = (index == ROWS*COLS-1) && out_valid.
- DONE: lasts exactly one cycle; done=1, busy=1, out_valid=0; then IDLE. A capture in the DONE cycle is ignored. The earliest new capture is accepted in the following IDLE cycle.
- Back-to-back throughput with out_ready held high: one word per cycle; a full drain takes ROWS*COLS cycles in STREAM plus 1 DONE cycle.
- Conversion (combinational from the snapshot element at the current index):
  - OUT_WIDTH >= ACCUM_WIDTH: sign-extend.
  - OUT_WIDTH < ACCUM_WIDTH with SATURATE=1: value > 2^(OUT_WIDTH-1)-1 -> max positive; value < -2^(OUT_WIDTH-1) -> min negative; otherwise keep the low OUT_WIDTH bits.
  - SATURATE=0: keep the low OUT_WIDTH bits (wraps).
- accum_in changing after capture has no effect on streamed data.
- out_data may be driven registered or from a registered index; either way it is stable for the whole valid cycle(s).

Test Plan:
- Reset then idle: no capture -> busy=0, out_valid=0, done=0, out_data=0 for 20 cycles.
- 2x2, ACCUM 40/OUT 32, SAT=1: accum_in elements {5,-3,100,-7}, capture pulse, out_ready=1 -> valid from the next cycle; words 5,-3,100,-7 with (row,col) (0,0),(0,1),(1,0),(1,1); out_last on the 4th word; done pulses the cycle after; busy drops the following cycle.
- Saturation: elements 2^35, -2^35, 2^31-1, -2^31 -> 0x7FFFFFFF, 0x80000000, 0x7FFFFFFF, 0x80000000. With SAT=0, 2^35+9 -> 9.
- Backpressure on a 4x4 array: out_ready toggled 1,0,0,1,... with random stalls -> exactly 16 transfers in row-major order, out_data stable across every stalled cycle, no duplicated or skipped indices.
- Snapshot isolation: capture, then change all accum_in to 0xFF.. and pulse capture mid-stream -> the original values are still streamed and the second capture is ignored. A capture in the IDLE cycle after done starts a new drain of the new values.
- Reset mid-stream at word 2 of 16 -> all outputs are 0 in the same cycle (async), no done pulse; a later capture restarts from (0,0).

Source files
------------

// File: rtl/systolic_result_drain.sv
// systolic_result_drain: snapshots every PE accumulator in one cycle on a
// capture request, then streams the values out in row-major order over a
// valid/ready interface. Each value is narrowed to OUT_WIDTH, with optional
// signed saturation.
module systolic_result_drain #(
   parameter int ROWS        = 4,
   parameter int COLS        = 4,
   parameter int ACCUM_WIDTH = 40,
   parameter int OUT_WIDTH   = 32,
   parameter int SATURATE    = 1,
   localparam int ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int COL_W      = (COLS > 1) ? $clog2(COLS) : 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              capture,
   input  logic [ROWS*COLS*ACCUM_WIDTH-1:0]  accum_in,
   output logic                              busy,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [OUT_WIDTH-1:0]              out_data,
   output logic [ROW_W-1:0]                  out_row,
   output logic [COL_W-1:0]                  out_col,
   output logic                              out_last,
   output logic                              done
);

   localparam int NUM   = ROWS * COLS;
   localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t state;
   state_t next_state;

   logic signed [ACCUM_WIDTH-1:0] snap [NUM];
   logic [IDX_W-1:0]              idx;
   logic [ROW_W-1:0]              row;
   logic [COL_W-1:0]              col;

   logic                          accept;
   logic                          transfer;
   logic                          at_last;
   logic signed [ACCUM_WIDTH-1:0] element;
   logic [OUT_WIDTH-1:0]          conv;

   assign accept   = (state == IDLE) && capture;
   assign transfer = (state == STREAM) && out_ready;
   assign at_last  = (idx == IDX_W'(NUM - 1));
   assign element  = snap[idx];

   // State register; reset abandons any drain in progress without a done pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state: IDLE -> STREAM on capture, STREAM -> DONE on the last transfer,
   // DONE always lasts exactly one cycle
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (capture) next_state = STREAM;
         STREAM:  if (out_ready && at_last) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Handshake outputs decoded purely from the state
   always_comb begin
      busy      = 1'b0;
      out_valid = 1'b0;
      done      = 1'b0;
      case (state)
         STREAM: begin
            busy      = 1'b1;
            out_valid = 1'b1;
         end
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   // Snapshot registers are loaded only when a capture is accepted in IDLE,
   // so the array may be reused straight away
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM; i++) begin
            snap[i] <= '0;
         end
      end else if (accept) begin
         for (int i = 0; i < NUM; i++) begin
            snap[i] <= accum_in[i*ACCUM_WIDTH +: ACCUM_WIDTH];
         end
      end
   end

   // Linear index plus separate row/column counters, advanced per transfer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx <= '0;
         row <= '0;
         col <= '0;
      end else if (accept) begin
         idx <= '0;
         row <= '0;
         col <= '0;
      end else if (transfer && !at_last) begin
         idx <= idx + IDX_W'(1);
         if (col == COL_W'(COLS - 1)) begin
            col <= '0;
            row <= row + ROW_W'(1);
         end else begin
            col <= col + COL_W'(1);
         end
      end
   end

   // Width conversion of the current snapshot element
   generate
      if ((SATURATE != 0) && (OUT_WIDTH < ACCUM_WIDTH)) begin : g_sat
         localparam logic signed [ACCUM_WIDTH-1:0] MAX_POS =
            {{(ACCUM_WIDTH - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
         localparam logic signed [ACCUM_WIDTH-1:0] MIN_NEG =
            {{(ACCUM_WIDTH - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

         // Clamp to the signed OUT_WIDTH range, else keep the low bits
         always_comb begin
            conv = OUT_WIDTH'(element);
            if (element > MAX_POS) begin
               conv = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
            end else if (element < MIN_NEG) begin
               conv = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
            end
         end
      end else begin : g_plain
         // Signed size cast sign-extends when widening and wraps when narrowing
         assign conv = OUT_WIDTH'(element);
      end
   endgenerate

   // Data-path outputs are forced to zero whenever no word is being offered
   always_comb begin
      out_data = out_valid ? conv : '0;
      out_row  = out_valid ? row  : '0;
      out_col  = out_valid ? col  : '0;
      out_last = out_valid && at_last;
   end

endmodule

// File: tb/tb_systolic_result_drain.sv
// tb_systolic_result_drain: randomized self-checking bench. DUT a is a 4x4
// array with saturation, DUT b is a 2x2 array that wraps. Expected words come
// from a plain arithmetic conversion model applied to the captured values.
module tb_systolic_result_drain;

   localparam int AW = 40;
   localparam int OW = 32;

   logic clk = 1'b0;
   logic reset;

   logic              a_capture;
   logic [16*AW-1:0]  a_accum;
   logic              a_busy;
   logic              a_valid;
   logic              a_ready;
   logic [OW-1:0]     a_data;
   logic [1:0]        a_row;
   logic [1:0]        a_col;
   logic              a_last;
   logic              a_done;

   logic              b_capture;
   logic [4*AW-1:0]   b_accum;
   logic              b_busy;
   logic              b_valid;
   logic              b_ready;
   logic [OW-1:0]     b_data;
   logic [0:0]        b_row;
   logic [0:0]        b_col;
   logic              b_last;
   logic              b_done;

   int num_checks = 0;
   int num_pass   = 0;

   longint a_vals [16];
   longint b_vals [4];

   longint max_pos;
   longint min_neg;

   systolic_result_drain #(
      .ROWS(4), .COLS(4), .ACCUM_WIDTH(AW), .OUT_WIDTH(OW), .SATURATE(1)
   ) dut_a (
      .clk(clk), .reset(reset), .capture(a_capture), .accum_in(a_accum),
      .busy(a_busy), .out_valid(a_valid), .out_ready(a_ready),
      .out_data(a_data), .out_row(a_row), .out_col(a_col),
      .out_last(a_last), .done(a_done)
   );

   systolic_result_drain #(
      .ROWS(2), .COLS(2), .ACCUM_WIDTH(AW), .OUT_WIDTH(OW), .SATURATE(0)
   ) dut_b (
      .clk(clk), .reset(reset), .capture(b_capture), .accum_in(b_accum),
      .busy(b_busy), .out_valid(b_valid), .out_ready(b_ready),
      .out_data(b_data), .out_row(b_row), .out_col(b_col),
      .out_last(b_last), .done(b_done)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      forever #5 clk = ~clk;
   end

   // Hard time limit so the run always terminates
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] got,
                              input logic [63:0] expected);
      num_checks++;
      if (got === expected) begin
         num_pass++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expected);
      end
   endtask

   function automatic logic [31:0] refConvert(input longint v, input bit sat);
      logic [63:0] raw;
      raw = v;
      if (sat && (v > max_pos)) return 32'h7FFF_FFFF;
      if (sat && (v < min_neg)) return 32'h8000_0000;
      return raw[31:0];
   endfunction

   function automatic longint randAccum();
      logic [39:0] t;
      longint v;
      case ($urandom_range(3, 0))
         0: v = longint'($urandom_range(2000, 0)) - 1000;
         1: v = max_pos + longint'($urandom_range(4, 0)) - 2;
         2: v = min_neg + longint'($urandom_range(4, 0)) - 2;
         default: begin
            t = {8'($urandom), 32'($urandom)};
            v = longint'($signed(t));
         end
      endcase
      return v;
   endfunction

   task automatic packA();
      for (int i = 0; i < 16; i++) a_accum[i*AW +: AW] = AW'(a_vals[i]);
   endtask

   task automatic packB();
      for (int i = 0; i < 4; i++) b_accum[i*AW +: AW] = AW'(b_vals[i]);
   endtask

   task automatic randomA();
      for (int i = 0; i < 16; i++) a_vals[i] = randAccum();
      packA();
   endtask

   // Pulse capture for one rising edge; returns at the following falling edge
   task automatic applyStimulus(input bit on_a);
      if (on_a) a_capture = 1'b1; else b_capture = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a_capture = 1'b0;
      b_capture = 1'b0;
   endtask

   // Drain DUT a: checks every offered word, optional random stalls, optional
   // captures mid-stream and in the DONE cycle (both must be ignored)
   task automatic drainA(input int stall_pct, input bit cap_mid, input bit cap_done);
      int k = 0;
      int cycles = 0;
      while (k < 16 && cycles < 400) begin
         checkOutput("a_valid", a_valid, 1);
         checkOutput("a_busy", a_busy, 1);
         checkOutput("a_data", a_data, refConvert(a_vals[k], 1'b1));
         checkOutput("a_row", a_row, k / 4);
         checkOutput("a_col", a_col, k % 4);
         checkOutput("a_last", a_last, (k == 15));
         checkOutput("a_done_early", a_done, 0);
         a_ready = ($urandom_range(99, 0) >= stall_pct);
         if (a_ready) k++;
         a_capture = cap_mid && (k >= 5) && (k < 9);
         @(posedge clk);
         @(negedge clk);
         cycles++;
      end
      checkOutput("a_word_count", k, 16);
      a_capture = cap_done;
      a_ready = 1'($urandom_range(1, 0));
      checkOutput("a_done_pulse", a_done, 1);
      checkOutput("a_done_valid", a_valid, 0);
      checkOutput("a_done_busy", a_busy, 1);
      checkOutput("a_done_last", a_last, 0);
      @(posedge clk);
      @(negedge clk);
      a_capture = 1'b0;
      checkOutput("a_idle_done", a_done, 0);
      checkOutput("a_idle_busy", a_busy, 0);
      checkOutput("a_idle_valid", a_valid, 0);
   endtask

   // Drain DUT b with out_ready held high, checking exact cycle timing
   task automatic drainB();
      b_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         checkOutput("b_valid", b_valid, 1);
         checkOutput("b_data", b_data, refConvert(b_vals[k], 1'b0));
         checkOutput("b_row", b_row, k / 2);
         checkOutput("b_col", b_col, k % 2);
         checkOutput("b_last", b_last, (k == 3));
         checkOutput("b_done_early", b_done, 0);
         @(posedge clk);
         @(negedge clk);
      end
      checkOutput("b_done_pulse", b_done, 1);
      checkOutput("b_done_busy", b_busy, 1);
      checkOutput("b_done_valid", b_valid, 0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("b_idle_busy", b_busy, 0);
      checkOutput("b_idle_done", b_done, 0);
   endtask

   initial begin
      max_pos = (longint'(1) << 31) - 1;
      min_neg = -(longint'(1) << 31);
      reset = 1'b1;
      a_capture = 1'b0;
      b_capture = 1'b0;
      a_ready = 1'b0;
      b_ready = 1'b0;
      a_accum = '0;
      b_accum = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Idle after reset: nothing offered for 20 cycles
      for (int i = 0; i < 20; i++) begin
         checkOutput("idle_busy", a_busy, 0);
         checkOutput("idle_valid", a_valid, 0);
         checkOutput("idle_done", a_done, 0);
         checkOutput("idle_data", a_data, 0);
         @(posedge clk);
         @(negedge clk);
      end
      checkOutput("idle_row", a_row, 0);
      checkOutput("idle_col", a_col, 0);
      checkOutput("idle_b_busy", b_busy, 0);

      // 2x2 basic ordering and timing
      b_vals = '{5, -3, 100, -7};
      packB();
      applyStimulus(1'b0);
      drainB();

      // 2x2 wrap without saturation
      b_vals[0] = (longint'(1) << 35) + 9;
      b_vals[1] = -(longint'(1) << 35);
      b_vals[2] = longint'(1) << 31;
      b_vals[3] = min_neg - 1;
      packB();
      applyStimulus(1'b0);
      drainB();

      // 4x4 saturation corners
      randomA();
      a_vals[0] = longint'(1) << 35;
      a_vals[1] = -(longint'(1) << 35);
      a_vals[2] = max_pos;
      a_vals[3] = min_neg;
      packA();
      applyStimulus(1'b1);
      drainA(0, 1'b0, 1'b0);

      // Random values with random backpressure
      for (int r = 0; r < 4; r++) begin
         randomA();
         applyStimulus(1'b1);
         drainA(50, 1'b0, 1'b0);
      end

      // Snapshot isolation: inputs change and capture pulses during the drain
      randomA();
      applyStimulus(1'b1);
      a_accum = '1;
      drainA(30, 1'b1, 1'b1);
      for (int i = 0; i < 16; i++) a_vals[i] = -1;
      applyStimulus(1'b1);
      drainA(20, 1'b0, 1'b0);

      // Asynchronous reset in the middle of a drain
      randomA();
      applyStimulus(1'b1);
      a_ready = 1'b1;
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
      end
      a_ready = 1'b0;
      checkOutput("pre_reset_data", a_data, refConvert(a_vals[2], 1'b1));
      checkOutput("pre_reset_col", a_col, 2);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("rst_valid", a_valid, 0);
      checkOutput("rst_busy", a_busy, 0);
      checkOutput("rst_data", a_data, 0);
      checkOutput("rst_row", a_row, 0);
      checkOutput("rst_col", a_col, 0);
      checkOutput("rst_last", a_last, 0);
      checkOutput("rst_done", a_done, 0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checkOutput("post_rst_done", a_done, 0);
         checkOutput("post_rst_valid", a_valid, 0);
         @(posedge clk);
         @(negedge clk);
      end
      randomA();
      applyStimulus(1'b1);
      drainA(40, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", num_pass, num_checks);
      $finish;
   end

endmodule
